// File: rtl/unidad_mult_div_if.sv
// -----------------------------------------------------------------------------
// unidad_mult_div_if
// Request / write-back bundle of the iterative multiply/divide unit.
//   master : requester side (drives start, op, sgn, dataA, dataB, wa_in;
//            observes busy, done and the register-bank write port)
//   slave  : the unidad_mult_div itself
// Signals:
//   start    request, accepted only while the unit is idle
//   op       00 mul low, 01 mul high, 10 div quotient, 11 div remainder
//   sgn      signed operation (only meaningful with MULDIV_SIGNED_EN)
//   dataA    multiplicand / dividend
//   dataB    multiplier / divisor
//   wa_in    destination register
//   busy     unit occupied
//   done     one-cycle completion pulse
//   wr_en    bank write enable (we)
//   wr_addr  bank write address (wa)
//   wr_data  bank write data (data_in)
// -----------------------------------------------------------------------------
interface unidad_mult_div_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) ();
    logic             start;
    logic [1:0]       op;
    logic             sgn;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [AW-1:0]    wa_in;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output start, op, sgn, dataA, dataB, wa_in,
        input  busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, op, sgn, dataA, dataB, wa_in,
        output busy, done, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/unidad_mult_div.sv
// -----------------------------------------------------------------------------
// unidad_mult_div
// Iterative multiply/divide unit of the execute stage. Operands read from the
// register bank are latched on an accepted start, WIDTH iterations of a
// shift-add (multiply) or restoring shift-subtract (divide) loop follow, and
// the selected result is written back through the bank write port.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    unidad_mult_div_if.slave (start/op/sgn/dataA/dataB/wa_in in,
//          busy/done/wr_en/wr_addr/wr_data out, all outputs registered)
//
// Optional feature macro:
//   MULDIV_SIGNED_EN  when defined, sgn=1 runs the loop on operand magnitudes
//                     and applies the sign at write-back. When undefined, sgn
//                     is ignored and everything is unsigned.
//
// Timing: accept edge E0, iterations on E1..E32, done/wr_en high between E32
// and E33, idle again after E33.
// -----------------------------------------------------------------------------
module unidad_mult_div #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    unidad_mult_div_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_WB   = 2'b10
    } state_t;

    localparam int         DW        = 2 * WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    // FSM
    state_t           state_r;
    state_t           state_nxt_s;
    logic             load_s;
    logic             iter_s;
    logic             finish_s;

    // Datapath state
    logic [5:0]       cnt_r;
    logic [DW-1:0]    acc_r;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] opnd_r;     // mul: multiplicand; div: divisor
    logic [1:0]       op_r;
    logic [AW-1:0]    wa_r;
    logic             div0_r;

    // Datapath combinational
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] opb_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [DW-1:0]    mul_step_s;
    logic [WIDTH:0]   div_part_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [DW-1:0]    div_step_s;
    logic [DW-1:0]    acc_nxt_s;
    logic [DW-1:0]    prod_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] result_s;

    // Output registers
    logic             busy_r;
    logic             done_r;
    logic             wr_en_r;
    logic [AW-1:0]    wr_addr_r;
    logic [WIDTH-1:0] wr_data_r;

`ifdef MULDIV_SIGNED_EN
    logic             sign_a_s;
    logic             sign_b_s;
    logic             neg_res_r;  // product / quotient negated at write-back
    logic             neg_rem_r;  // remainder follows the dividend sign

    // Two's complement magnitude of a value flagged negative.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             neg);
        magnitude = neg ? (-x) : x;
    endfunction

    // Operand magnitudes presented to the loop at accept.
    always_comb begin
        sign_a_s = bus.sgn & bus.dataA[WIDTH-1];
        sign_b_s = bus.sgn & bus.dataB[WIDTH-1];
        opa_s    = magnitude(bus.dataA, sign_a_s);
        opb_s    = magnitude(bus.dataB, sign_b_s);
    end
`else
    logic sgn_unused_s;
    assign sgn_unused_s = bus.sgn;

    // Unsigned build: operands enter the loop unchanged.
    always_comb begin
        opa_s = bus.dataA;
        opb_s = bus.dataB;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and datapath control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = S_CALC;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CALC: begin
                iter_s = 1'b1;
                if (cnt_r == LAST_ITER) begin
                    // The final iteration also loads the write-back registers,
                    // so the result is visible during the WB cycle.
                    state_nxt_s = S_WB;
                    finish_s    = 1'b1;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_WB: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // One multiply or divide iteration computed from the current accumulator.
    always_comb begin
        // Shift-add: conditionally add multiplicand to upper half, then shift right.
        mul_sum_s  = {1'b0, acc_r[DW-1:WIDTH]} + ({1'b0, opnd_r} & {(WIDTH+1){acc_r[0]}});
        mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // Restoring divide: shift left, trial-subtract divisor from the remainder.
        // When the trial succeeds the true difference fits in WIDTH bits, so
        // the low WIDTH bits of the subtraction are exact.
        div_part_s = acc_r[DW-1:WIDTH-1];
        div_ge_s   = (div_part_s >= {1'b0, opnd_r});
        div_diff_s = div_part_s[WIDTH-1:0] - opnd_r;
        if (div_ge_s) begin
            div_step_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {div_part_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        if (op_r[1]) begin
            acc_nxt_s = div_step_s;
        end else begin
            acc_nxt_s = mul_step_s;
        end
    end

    // Result selection from the accumulator after the last iteration.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod_s = neg_res_r ? (-acc_nxt_s) : acc_nxt_s;
        quot_s = neg_res_r ? (-acc_nxt_s[WIDTH-1:0]) : acc_nxt_s[WIDTH-1:0];
        rem_s  = neg_rem_r ? (-acc_nxt_s[DW-1:WIDTH]) : acc_nxt_s[DW-1:WIDTH];
`else
        prod_s = acc_nxt_s;
        quot_s = acc_nxt_s[WIDTH-1:0];
        rem_s  = acc_nxt_s[DW-1:WIDTH];
`endif
        // Divide by zero: all-ones quotient regardless of signs. The remainder
        // already equals the dividend (magnitude re-signed by dividend sign).
        if (div0_r) begin
            quot_s = {WIDTH{1'b1}};
        end else begin
            quot_s = quot_s;
        end

        case (op_r)
            2'b00:   result_s = prod_s[WIDTH-1:0];
            2'b01:   result_s = prod_s[DW-1:WIDTH];
            2'b10:   result_s = quot_s;
            2'b11:   result_s = rem_s;
            default: result_s = prod_s[WIDTH-1:0];
        endcase
    end

    // Operand latch on accept and one iteration per cycle in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 6'd0;
            acc_r  <= {DW{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
            op_r   <= 2'b00;
            wa_r   <= {AW{1'b0}};
            div0_r <= 1'b0;
        end else if (load_s) begin
            cnt_r  <= 6'd0;
            op_r   <= bus.op;
            wa_r   <= bus.wa_in;
            div0_r <= bus.op[1] & (bus.dataB == {WIDTH{1'b0}});
            if (bus.op[1]) begin
                acc_r  <= {{WIDTH{1'b0}}, opa_s};
                opnd_r <= opb_s;
            end else begin
                acc_r  <= {{WIDTH{1'b0}}, opb_s};
                opnd_r <= opa_s;
            end
        end else if (iter_s) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + 6'd1;
        end
    end

`ifdef MULDIV_SIGNED_EN
    // Sign flags captured at accept, applied at write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load_s) begin
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
        end
    end
`endif

    // Registered outputs: busy tracks the next state, write port loads on finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {WIDTH{1'b0}};
        end else begin
            busy_r  <= (state_nxt_s != S_IDLE);
            done_r  <= finish_s;
            // Register 0 is hard-wired in the bank: never write it.
            wr_en_r <= finish_s & (wa_r != {AW{1'b0}});
            if (finish_s) begin
                wr_addr_r <= wa_r;
                wr_data_r <= result_s;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_unidad_mult_div.sv
// -----------------------------------------------------------------------------
// tb_unidad_mult_div
// Directed-vector bench for unidad_mult_div. Each task drives one scenario and
// checks against hand-computed values.
// -----------------------------------------------------------------------------
module tb_unidad_mult_div;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    unidad_mult_div_if #(.WIDTH(32), .AW(5)) bus ();

    unidad_mult_div #(.WIDTH(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    // Issue one operation and wait (bounded) for its done pulse.
    // lat counts edges after the accept edge until done is seen (expect 32).
    task automatic do_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] w,
                         output int lat, output logic [31:0] d, output logic en,
                         output logic [4:0] ad, output logic busy_acc,
                         output logic busy_end, output logic done_end);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.sgn = s;
        bus.dataA = a; bus.dataB = b; bus.wa_in = w;
        @(posedge clk); #1;
        busy_acc  = bus.busy;
        // Scramble inputs after accept: only latched values may matter.
        bus.start = 1'b0; bus.op = ~o; bus.sgn = ~s;
        bus.dataA = 32'hDEAD_BEEF; bus.dataB = 32'h0BAD_F00D; bus.wa_in = 5'd31;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = bus.wr_data;
        en = bus.wr_en;
        ad = bus.wr_addr;
        @(posedge clk); #1;
        busy_end = bus.busy;
        done_end = bus.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.sgn = 1'b0;
        bus.dataA = 32'd0; bus.dataB = 32'd0; bus.wa_in = 5'd0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        total++; if (bus.wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
        total++; if (bus.wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int lat; logic [31:0] d; logic en, ba, be, de; logic [4:0] ad;
        do_op(2'b00, 1'b0, 32'd7, 32'd6, 5'd3, lat, d, en, ad, ba, be, de);
        total++; if (ba !== 1'b1) begin bad++; $display("FAIL mul_busy_accept: got %b want 1", ba); end
        total++; if (lat != 32) begin bad++; $display("FAIL mul_latency: got %0d want 32", lat); end
        total++; if (d !== 32'd42) begin bad++; $display("FAIL mul_7x6: got %h want 0000002a", d); end
        total++; if (en !== 1'b1) begin bad++; $display("FAIL mul_wr_en: got %b want 1", en); end
        total++; if (ad !== 5'd3) begin bad++; $display("FAIL mul_wr_addr: got %0d want 3", ad); end
        total++; if (be !== 1'b0 || de !== 1'b0) begin bad++; $display("FAIL mul_end_idle: got busy=%b done=%b want 0 0", be, de); end
        do_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulh_ones: got %h want fffffffe", d); end
        do_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL mull_ones: got %h want 00000001", d); end
        do_op(2'b01, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL mulh_2p32: got %h want 00000001", d); end
        do_op(2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL mull_2p32: got %h want 00000000", d); end
    endtask

    task automatic test_div();
        int lat; logic [31:0] d; logic en, ba, be, de; logic [4:0] ad;
        do_op(2'b10, 1'b0, 32'd100, 32'd7, 5'd7, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'd14) begin bad++; $display("FAIL div_q_100_7: got %h want 0000000e", d); end
        total++; if (lat != 32) begin bad++; $display("FAIL div_latency: got %0d want 32", lat); end
        do_op(2'b11, 1'b0, 32'd100, 32'd7, 5'd7, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL div_r_100_7: got %h want 00000002", d); end
        do_op(2'b10, 1'b0, 32'd5, 32'd0, 5'd8, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_q: got %h want ffffffff", d); end
        do_op(2'b11, 1'b0, 32'd5, 32'd0, 5'd8, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL div0_r: got %h want 00000005", d); end
        do_op(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd9, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0FFF_FFFF) begin bad++; $display("FAIL div_q_max_16: got %h want 0fffffff", d); end
        do_op(2'b11, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd9, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_000F) begin bad++; $display("FAIL div_r_max_16: got %h want 0000000f", d); end
        do_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL divu_q_small_big: got %h want 00000000", d); end
        do_op(2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL divu_r_small_big: got %h want 80000000", d); end
    endtask

    task automatic test_back_to_back();
        int first_c, second_c;
        logic busy_gap;
        logic [31:0] d2;
        first_c = -1; second_c = -1; busy_gap = 1'b1; d2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.sgn = 1'b0;
        bus.dataA = 32'd3; bus.dataB = 32'd5; bus.wa_in = 5'd4;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                if (first_c < 0) first_c = c;
                else if (second_c < 0) begin second_c = c; d2 = bus.wr_data; end
            end
            if (c == 33) busy_gap = bus.busy;
            if (c == 40) bus.start = 1'b0;
        end
        total++; if (first_c != 32) begin bad++; $display("FAIL b2b_first_done: got %0d want 32", first_c); end
        total++; if (second_c != 66) begin bad++; $display("FAIL b2b_second_done: got %0d want 66", second_c); end
        total++; if (busy_gap !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_gap); end
        total++; if (d2 !== 32'd15) begin bad++; $display("FAIL b2b_data: got %h want 0000000f", d2); end
    endtask

    task automatic test_ignore_start();
        int n_done, n_wr, lat;
        logic [31:0] d_seen, d;
        logic [4:0] a_seen, ad;
        logic en, ba, be, de;
        n_done = 0; n_wr = 0; d_seen = 32'd0; a_seen = 5'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.sgn = 1'b0;
        bus.dataA = 32'd7; bus.dataB = 32'd6; bus.wa_in = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            bus.start = (c == 5 || c == 20);
            bus.op = 2'b10; bus.dataA = 32'd100; bus.dataB = 32'd7; bus.wa_in = 5'd9;
            @(posedge clk); #1;
            if (bus.done === 1'b1) n_done++;
            if (bus.wr_en === 1'b1) begin n_wr++; d_seen = bus.wr_data; a_seen = bus.wr_addr; end
        end
        bus.start = 1'b0;
        total++; if (n_done != 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
        total++; if (n_wr != 1) begin bad++; $display("FAIL ign_wr_count: got %0d want 1", n_wr); end
        total++; if (d_seen !== 32'd42 || a_seen !== 5'd3) begin bad++; $display("FAIL ign_result: got %h@%0d want 0000002a@3", d_seen, a_seen); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_idle_after: got busy=%b want 0", bus.busy); end
        do_op(2'b00, 1'b0, 32'd2, 32'd3, 5'd0, lat, d, en, ad, ba, be, de);
        total++; if (lat != 32) begin bad++; $display("FAIL r0_done: got latency %0d want 32", lat); end
        total++; if (en !== 1'b0) begin bad++; $display("FAIL r0_wr_en: got %b want 0", en); end
    endtask

    task automatic test_reset_mid();
        int n_wr, lat;
        logic [31:0] d;
        logic [4:0] ad;
        logic en, ba, be, de;
        n_wr = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.sgn = 1'b0;
        bus.dataA = 32'd100; bus.dataB = 32'd7; bus.wa_in = 5'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b wr_en=%b want 0 0 0", bus.busy, bus.done, bus.wr_en);
        end
        total++; if (bus.wr_data !== 32'd0 || bus.wr_addr !== 5'd0) begin
            bad++; $display("FAIL midrst_port: got %h@%0d want 00000000@0", bus.wr_data, bus.wr_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.wr_en === 1'b1 || bus.done === 1'b1) n_wr++;
        end
        total++; if (n_wr != 0) begin bad++; $display("FAIL midrst_no_write: got %0d pulses want 0", n_wr); end
        do_op(2'b10, 1'b0, 32'd100, 32'd7, 5'd6, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'd14 || en !== 1'b1 || ad !== 5'd6) begin
            bad++; $display("FAIL midrst_recover: got %h en=%b @%0d want 0000000e en=1 @6", d, en, ad);
        end
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        int lat; logic [31:0] d; logic en, ba, be, de; logic [4:0] ad;
        do_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd10, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sdiv_q_m7_2: got %h want fffffffd", d); end
        total++; if (lat != 32) begin bad++; $display("FAIL sdiv_latency: got %0d want 32", lat); end
        do_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd10, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv_r_m7_2: got %h want ffffffff", d); end
        do_op(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd4, 5'd11, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFF4) begin bad++; $display("FAIL smul_lo_m3_4: got %h want fffffff4", d); end
        do_op(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd4, 5'd11, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL smul_hi_m3_4: got %h want ffffffff", d); end
        do_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL smul_hi_m1_m1: got %h want 00000000", d); end
        do_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL sdiv_q_min_m1: got %h want 80000000", d); end
        do_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL sdiv_r_min_m1: got %h want 00000000", d); end
        do_op(2'b10, 1'b1, 32'hFFFF_FFFB, 32'd0, 5'd13, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv0_q: got %h want ffffffff", d); end
        do_op(2'b11, 1'b1, 32'hFFFF_FFFB, 32'd0, 5'd13, lat, d, en, ad, ba, be, de);
        total++; if (d !== 32'hFFFF_FFFB) begin bad++; $display("FAIL sdiv0_r: got %h want fffffffb", d); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
